cbus_mem_responder: RTL
=======================

Name: cbus_mem_responder

Overview:
Responder end of the core's cache-bus (cbus) protocol: a synchronous on-chip RAM model that services the arbitrated cbus_req_t stream issued by the core/arbiter and returns cbus_resp_t. Supports single and burst (len+1 beats) reads and writes with byte strobes and a programmable first-beat latency. Used as the memory behind the arbiter in simulation tops and FPGA bring-up builds.

Parameters:
DEPTH_WORDS, 65536, number of 64-bit words backed (power of two)
BASE_ADDR, 64'h8000_0000, byte address mapped to word 0
LATENCY, 2, idle cycles between request acceptance and first data beat (0..15)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
creq  input  cbus_req_t  request: valid, is_write, size[2:0], addr[63:0], strobe[7:0], data[63:0], len[7:0] (beats-1), burst[1:0]
cresp  output  cbus_resp_t  response: ready, last, data[63:0]

Behaviour:
- Reset (synchronous, active-high): FSM -> IDLE; cresp.ready=0, cresp.last=0, cresp.data=0; beat and latency counters cleared. RAM contents not cleared. Reset mid-burst abandons the transaction; no further beats are issued for it.
- Handshake: initiator holds creq.valid and all control fields stable from assertion until the cycle after ready&last. Every beat is a one-cycle cresp.ready pulse. On a write beat, creq.data/strobe are sampled in the ready cycle; the initiator advances its data after seeing ready. On a read beat, cresp.data is valid in the ready cycle.
- FSM:
  IDLE: when creq.valid, latch is_write, addr, len, burst; lat_cnt=LATENCY; -> WAIT (-> BURST directly if LATENCY==0).
  WAIT: decrement lat_cnt each cycle; at 0 -> BURST.
  BURST: assert ready every cycle (one beat per cycle, no bubbles). beat_cnt counts 0..len; last=1 when beat_cnt==len. On the last beat -> DONE.
  DONE: ready=0, last=0 for exactly one cycle (lets valid drop); -> IDLE. A new request is accepted no earlier than the cycle after DONE.
- Earliest first beat: LATENCY+1 cycles after valid is first seen in IDLE.
- Addressing: word index = (addr - BASE_ADDR) >> 3, taken modulo DEPTH_WORDS. burst INCR (2'b01): index increments per beat, wrapping at DEPTH_WORDS. burst FIXED (2'b00): same index every beat. Other encodings are treated as INCR.
- Out-of-range: addr < BASE_ADDR or addr >= BASE_ADDR+8*DEPTH_WORDS -> reads return 64'h0, writes are discarded; handshake timing unchanged (no error signalling).
- Writes: byte lane i is updated iff strobe[i]; size is informational only (strobe governs). Read-after-write to the same word in a later transaction returns the new data.
- Read data comes from a registered RAM read issued one cycle ahead, so ready and data align with no combinational path from creq.addr to cresp.data.
- cresp.data=0 whenever ready=0 and on write beats.
- If creq.valid drops mid-burst (protocol violation), the FSM finishes the burst as latched; the bench flags this as an error.

Test Plan:
- Reset: hold reset 3 cycles while valid=1 -> ready=0, last=0, data=0 throughout; FSM in IDLE on release; request begins from scratch.
- Single write then read, LATENCY=2: write addr 0x8000_0010, data 0x1122334455667788, strobe 0xFF, len=0 -> ready&last in cycle 3 after valid; read same addr -> data 0x1122334455667788 with ready&last in cycle 3.
- Strobe merge: word preset to all 0s, write data 0xFFFF_FFFF_FFFF_FFFF with strobe 0x0F -> readback 0x0000_0000_FFFF_FFFF.
- INCR burst len=7 from 0x8000_0100 over pre-written 0..7 -> 8 back-to-back ready beats returning 0..7, last only on beat 8, then one idle DONE cycle.
- Boundaries: FIXED burst len=3 returns the same word 4 times; INCR burst starting at the last word wraps to word 0; read at 0x7FFF_FFF8 returns 0 with normal timing, and a write there changes no RAM word.
- LATENCY=0 build: first beat in cycle 1; reset asserted at beat 3 of an 8-beat read -> ready drops next cycle, no further beats, and the next request is served correctly.

Source files
------------

// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder
//   Responder end of the cache-bus (cbus). Synchronous RAM model that serves
//   single and burst reads/writes with byte strobes and a fixed first-beat
//   latency. It is used behind the arbiter in simulation tops and FPGA
//   bring-up builds.
//
// Handshake: the initiator holds i_creq_valid and every control field stable
//   from assertion until the cycle after o_cresp_ready & o_cresp_last. Each
//   beat is a one-cycle o_cresp_ready pulse. On a write beat, i_creq_data and
//   i_creq_strobe are sampled in the ready cycle. On a read beat,
//   o_cresp_data is valid in the ready cycle and is 0 at all other times.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   i_creq_valid       request valid (held for the whole transaction)
//   i_creq_is_write    1 = write, 0 = read
//   i_creq_size        informational only; the strobes decide which lanes are written
//   i_creq_addr        byte address of the first beat
//   i_creq_strobe      write byte enables, one bit per byte lane
//   i_creq_data        write data
//   i_creq_len         beats-1
//   i_creq_burst       2'b00 FIXED, any other value INCR
//   o_cresp_ready      beat strobe
//   o_cresp_last       final beat of the transaction
//   o_cresp_data       read data
//   o_state            FSM state (IDLE=0, WAIT=1, BURST=2, DONE=3), for debug
module cbus_mem_responder #(
    parameter int          DEPTH_WORDS = 65536,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_creq_valid,
    input  logic        i_creq_is_write,
    input  logic [2:0]  i_creq_size,
    input  logic [63:0] i_creq_addr,
    input  logic [7:0]  i_creq_strobe,
    input  logic [63:0] i_creq_data,
    input  logic [7:0]  i_creq_len,
    input  logic [1:0]  i_creq_burst,
    output logic        o_cresp_ready,
    output logic        o_cresp_last,
    output logic [63:0] o_cresp_data,
    output logic [1:0]  o_state
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_is_write;
    logic            r_fixed;
    logic            r_oor;
    logic [7:0]      r_len;
    logic [7:0]      r_beat;
    logic [3:0]      r_lat;
    logic [AW-1:0]   r_idx;
    logic [63:0]     r_rdata;
    logic [63:0]     r_mem [DEPTH_WORDS];

    logic [63:0]     w_offset;
    logic            w_in_range;
    logic [AW-1:0]   w_req_idx;
    logic [AW-1:0]   w_next_idx;
    logic [AW-1:0]   w_rd_idx;
    logic            w_last;
    logic            w_unused;

    // The word index wraps modulo DEPTH_WORDS simply by keeping only AW bits.
    assign w_offset   = i_creq_addr - BASE_ADDR;
    assign w_in_range = (i_creq_addr >= BASE_ADDR) && (w_offset < SPAN);
    assign w_req_idx  = w_offset[AW+2:3];
    assign w_next_idx = r_fixed ? r_idx : r_idx + 1'b1;
    assign w_last     = (r_beat == r_len);
    assign w_unused   = ^{i_creq_size, w_offset[63:AW+3], w_offset[2:0]};
    assign o_state    = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_is_write <= 1'b0;
            r_fixed    <= 1'b0;
            r_oor      <= 1'b0;
            r_len      <= 8'd0;
            r_beat     <= 8'd0;
            r_lat      <= 4'd0;
            r_idx      <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (i_creq_valid) begin
                        r_is_write <= i_creq_is_write;
                        r_fixed    <= (i_creq_burst == 2'b00);
                        r_oor      <= !w_in_range;
                        r_len      <= i_creq_len;
                        r_idx      <= w_req_idx;
                        r_beat     <= 8'd0;
                        // WAIT spends LATENCY cycles, so count down from LATENCY-1.
                        r_lat      <= 4'(LATENCY - 1);
                    end
                end
                S_WAIT: begin
                    if (r_lat != 4'd0) r_lat <= r_lat - 4'd1;
                end
                S_BURST: begin
                    r_beat <= r_beat + 8'd1;
                    r_idx  <= w_next_idx;
                end
                default: ;
            endcase
        end
    end

    // RAM. The read is issued a cycle ahead (w_rd_idx is the index of the next
    // beat), so r_rdata already holds the current beat's word when ready rises.
    always_ff @(posedge clk) begin
        r_rdata <= r_mem[w_rd_idx];
        if (r_state == S_BURST && r_is_write && !r_oor) begin
            for (int i = 0; i < 8; i++) begin
                if (i_creq_strobe[i]) r_mem[r_idx][i*8 +: 8] <= i_creq_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rd_idx      = r_idx;
        o_cresp_ready = 1'b0;
        o_cresp_last  = 1'b0;
        o_cresp_data  = 64'd0;
        case (r_state)
            S_IDLE: begin
                w_rd_idx = w_req_idx;
                if (i_creq_valid) w_state_nxt = (LATENCY == 0) ? S_BURST : S_WAIT;
            end
            S_WAIT: begin
                if (r_lat == 4'd0) w_state_nxt = S_BURST;
            end
            S_BURST: begin
                w_rd_idx      = w_next_idx;
                o_cresp_ready = 1'b1;
                o_cresp_last  = w_last;
                if (!r_is_write && !r_oor) o_cresp_data = r_rdata;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
